// File: rtl/tcdm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_rr_arbiter
// Description : Shares one TCDM-style master port (req/gnt/r_valid) between
//               N_PORTS requesters. Round-robin arbitration on the request
//               channel with zero added latency. Responses are routed back
//               in order through an ID FIFO that holds the indices of the
//               granted requesters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   s_req_i/s_gnt_o     per-port request / grant
//   s_add_i, s_wen_i,   per-port address, write-enable (active-low),
//   s_wdata_i, s_be_i   write data and byte enables (port k at slice k)
//   s_r_valid_o         per-port response valid
//   s_r_rdata_o/opc_o   response data / error, broadcast to all ports
//   m_*                 shared master port toward the interconnect
//   busy_o              high while transactions are outstanding
// Build option
//   TCDM_ARB_PRIO0_EN   port 0 gets absolute priority over the RR ports
// ============================================================================
module tcdm_rr_arbiter #(
   parameter int N_PORTS         = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [N_PORTS-1:0]               s_req_i,
   input  logic [N_PORTS*ADDR_WIDTH-1:0]    s_add_i,
   input  logic [N_PORTS-1:0]               s_wen_i,
   input  logic [N_PORTS*DATA_WIDTH-1:0]    s_wdata_i,
   input  logic [N_PORTS*DATA_WIDTH/8-1:0]  s_be_i,
   output logic [N_PORTS-1:0]               s_gnt_o,
   output logic [N_PORTS-1:0]               s_r_valid_o,
   output logic [DATA_WIDTH-1:0]            s_r_rdata_o,
   output logic                             s_r_opc_o,
   output logic                             m_req_o,
   output logic [ADDR_WIDTH-1:0]            m_add_o,
   output logic                             m_wen_o,
   output logic [DATA_WIDTH-1:0]            m_wdata_o,
   output logic [DATA_WIDTH/8-1:0]          m_be_o,
   input  logic                             m_gnt_i,
   input  logic                             m_r_valid_i,
   input  logic [DATA_WIDTH-1:0]            m_r_rdata_i,
   input  logic                             m_r_opc_i,
   output logic                             busy_o
);

   localparam int c_be_w  = DATA_WIDTH / 8;
   localparam int c_idx_w = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);

   logic [c_idx_w-1:0] r_rr_ptr;
   logic [c_idx_w-1:0] r_fifo [MAX_OUTSTANDING];
   logic [c_ptr_w-1:0] r_wptr;
   logic [c_ptr_w-1:0] r_rptr;
   logic [c_cnt_w-1:0] r_count;

   logic               w_fifo_empty;
   logic               w_fifo_full;
   logic [c_idx_w:0]   w_scan;
   logic [c_idx_w-1:0] w_win_idx;
   logic               w_win_valid;
   logic               w_hs;
   logic               w_pop;
   logic               w_rr_upd;
   logic [c_idx_w-1:0] w_rr_next;
   logic [c_idx_w-1:0] w_head;
   logic [c_ptr_w-1:0] w_wptr_next;
   logic [c_ptr_w-1:0] w_rptr_next;

   assign w_fifo_empty = (r_count == '0);
   assign w_fifo_full  = (r_count == c_cnt_w'(MAX_OUTSTANDING));
   assign w_head       = r_fifo[r_rptr];

   // Scan downward over the offsets so that the last hit, i.e. the one
   // closest to r_rr_ptr, is the winner. The sum is one bit wider so the
   // modulo wrap works for non-power-of-two port counts.
   always_comb begin
      w_win_valid = 1'b0;
      w_win_idx   = '0;
      w_scan      = '0;
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         w_scan = {1'b0, r_rr_ptr} + (c_idx_w + 1)'(i);
         if (w_scan >= (c_idx_w + 1)'(N_PORTS)) begin
            w_scan = w_scan - (c_idx_w + 1)'(N_PORTS);
         end
         if (s_req_i[w_scan[c_idx_w-1:0]]) begin
            w_win_valid = 1'b1;
            w_win_idx   = w_scan[c_idx_w-1:0];
         end
      end
`ifdef TCDM_ARB_PRIO0_EN
      if (s_req_i[0]) begin
         w_win_valid = 1'b1;
         w_win_idx   = '0;
      end
`endif
   end

   // A full FIFO blocks the request even when a pop happens this cycle;
   // the freed slot becomes usable on the next cycle.
   assign m_req_o = (|s_req_i) & ~w_fifo_full;
   assign w_hs    = m_req_o & m_gnt_i;
   assign w_pop   = m_r_valid_i & ~w_fifo_empty;

`ifdef TCDM_ARB_PRIO0_EN
   // Port 0 handshakes must not disturb the rotation among ports 1..N-1.
   assign w_rr_upd = w_hs & (w_win_idx != '0);
`else
   assign w_rr_upd = w_hs;
`endif

   assign w_rr_next   = (w_win_idx == c_idx_w'(N_PORTS - 1)) ? '0 : w_win_idx + c_idx_w'(1);
   assign w_wptr_next = (r_wptr == c_ptr_w'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + c_ptr_w'(1);
   assign w_rptr_next = (r_rptr == c_ptr_w'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + c_ptr_w'(1);

   // Request-field mux: winner's fields, zero when nobody requests.
   always_comb begin
      m_add_o   = '0;
      m_wen_o   = 1'b0;
      m_wdata_o = '0;
      m_be_o    = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (w_win_valid && (w_win_idx == c_idx_w'(k))) begin
            m_add_o   = s_add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            m_wen_o   = s_wen_i[k];
            m_wdata_o = s_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            m_be_o    = s_be_i[k*c_be_w +: c_be_w];
         end
      end
   end

   generate
      for (genvar k = 0; k < N_PORTS; k++) begin : g_port
         assign s_gnt_o[k]     = w_hs  & (w_win_idx == c_idx_w'(k));
         assign s_r_valid_o[k] = w_pop & (w_head == c_idx_w'(k));
      end
   endgenerate

   assign s_r_rdata_o = m_r_rdata_i;
   assign s_r_opc_o   = m_r_opc_i;
   assign busy_o      = ~w_fifo_empty;

   // ID FIFO storage needs no reset: entries are only read below r_count.
   always_ff @(posedge clk_i) begin
      if (w_hs) begin
         r_fifo[r_wptr] <= w_win_idx;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rr_ptr <= '0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
      end else begin
         if (w_rr_upd) begin
            r_rr_ptr <= w_rr_next;
         end
         if (w_hs) begin
            r_wptr <= w_wptr_next;
         end
         if (w_pop) begin
            r_rptr <= w_rptr_next;
         end
         case ({w_hs, w_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
         // A response with nothing outstanding is dropped; flag it.
         assert (!(m_r_valid_i && w_fifo_empty))
            else $warning("tcdm_rr_arbiter: spurious response dropped (no outstanding ID)");
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tcdm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcdm_rr_arbiter
// Description : Directed self-checking bench for tcdm_rr_arbiter
//               (N_PORTS=4, 32-bit address/data, MAX_OUTSTANDING=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    s_req;
   logic [N*AW-1:0] s_add;
   logic [N-1:0]    s_wen;
   logic [N*DW-1:0] s_wdata;
   logic [N*DW/8-1:0] s_be;
   logic [N-1:0]    s_gnt;
   logic [N-1:0]    s_r_valid;
   logic [DW-1:0]   s_r_rdata;
   logic            s_r_opc;
   logic            m_req;
   logic [AW-1:0]   m_add;
   logic            m_wen;
   logic [DW-1:0]   m_wdata;
   logic [DW/8-1:0] m_be;
   logic            m_gnt;
   logic            m_r_valid;
   logic [DW-1:0]   m_r_rdata;
   logic            m_r_opc;
   logic            busy;

   int n_vec = 0;
   int n_err = 0;

   tcdm_rr_arbiter #(
      .N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .s_req_i(s_req), .s_add_i(s_add), .s_wen_i(s_wen),
      .s_wdata_i(s_wdata), .s_be_i(s_be),
      .s_gnt_o(s_gnt), .s_r_valid_o(s_r_valid),
      .s_r_rdata_o(s_r_rdata), .s_r_opc_o(s_r_opc),
      .m_req_o(m_req), .m_add_o(m_add), .m_wen_o(m_wen),
      .m_wdata_o(m_wdata), .m_be_o(m_be),
      .m_gnt_i(m_gnt), .m_r_valid_i(m_r_valid),
      .m_r_rdata_i(m_r_rdata), .m_r_opc_i(m_r_opc),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      s_req = '0; s_add = '0; s_wen = '0; s_wdata = '0; s_be = '0;
      m_gnt = 1'b0; m_r_valid = 1'b0; m_r_rdata = '0; m_r_opc = 1'b0;
   endtask

   logic [3:0]  exp_g;
   logic [3:0]  prev_g;
   int          gcnt [4];
   logic [3:0]  drain_exp [4];
   logic [3:0]  ord_port [3];
   logic [31:0] ord_data [3];
   logic        ord_opc  [3];

   initial begin
      // ---------------- reset state ----------------
      rst = 1'b1;
      clr();
      tick(); tick();
      @(negedge clk);
      chk("rst_m_req", 64'(m_req), 64'd0);
      chk("rst_gnt", 64'(s_gnt), 64'd0);
      chk("rst_rvalid", 64'(s_r_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_m_add", 64'(m_add), 64'd0);
      tick();
      rst = 1'b0;

      // ---------------- single requester: port 2 read ----------------
      s_req[2] = 1'b1;
      s_add[2*AW +: AW] = 32'h1C00_0010;
      s_wen[2] = 1'b1;
      s_be[2*4 +: 4] = 4'hF;
      m_gnt = 1'b1;
      @(negedge clk);
      chk("single_gnt", 64'(s_gnt), 64'b0100);
      chk("single_add", 64'(m_add), 64'h1C00_0010);
      chk("single_wen", 64'(m_wen), 64'd1);
      chk("single_be", 64'(m_be), 64'hF);
      chk("single_busy0", 64'(busy), 64'd0);
      tick();
      clr();
      m_r_valid = 1'b1;
      m_r_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("single_busy1", 64'(busy), 64'd1);
      chk("single_rvalid", 64'(s_r_valid), 64'b0100);
      chk("single_rdata", 64'(s_r_rdata), 64'hDEAD_BEEF);
      tick();
      m_r_valid = 1'b0;
      @(negedge clk);
      chk("single_busy_end", 64'(busy), 64'd0);

      // re-align the RR pointer to 0
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();

      // ---------------- fairness: all ports requesting ----------------
      for (int k = 0; k < 4; k++) begin
         gcnt[k] = 0;
         s_add[k*AW +: AW] = 32'hA000_0000 + 32'(k);
      end
      s_req = 4'hF;
      m_gnt = 1'b1;
      prev_g = '0;
      for (int c = 0; c < 8; c++) begin
         m_r_valid = (c > 0);
         @(negedge clk);
`ifdef TCDM_ARB_PRIO0_EN
         exp_g = 4'b0001;
`else
         exp_g = 4'(1 << (c % 4));
`endif
         chk("fair_gnt", 64'(s_gnt), 64'(exp_g));
         chk("fair_add", 64'(m_add), 64'(32'hA000_0000 + 32'($clog2(int'(exp_g)))));
         if (c > 0) chk("fair_route", 64'(s_r_valid), 64'(prev_g));
         for (int k = 0; k < 4; k++) gcnt[k] += int'(s_gnt[k]);
         prev_g = exp_g;
         tick();
      end
      for (int k = 0; k < 4; k++) begin
`ifdef TCDM_ARB_PRIO0_EN
         chk("fair_count", 64'(gcnt[k]), (k == 0) ? 64'd8 : 64'd0);
`else
         chk("fair_count", 64'(gcnt[k]), 64'd2);
`endif
      end
      s_req = '0;
      m_gnt = 1'b0;
      m_r_valid = 1'b1;
      @(negedge clk);
      chk("fair_drain", 64'(s_r_valid), 64'(prev_g));
      tick();
      m_r_valid = 1'b0;
      @(negedge clk);
      chk("fair_idle", 64'(busy), 64'd0);
      tick();

      // ---------------- backpressure: ports 1 and 3 ----------------
      s_req = 4'b1010;
      s_add[1*AW +: AW] = 32'h1000_0004;
      s_add[3*AW +: AW] = 32'h3000_000C;
      m_gnt = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_add", 64'(m_add), 64'h1000_0004);
         chk("bp_gnt", 64'(s_gnt), 64'd0);
         chk("bp_req", 64'(m_req), 64'd1);
         tick();
      end
      m_gnt = 1'b1;
      @(negedge clk);
      chk("bp_first", 64'(s_gnt), 64'b0010);
      tick();
      @(negedge clk);
      chk("bp_second", 64'(s_gnt), 64'b1000);
      chk("bp_add3", 64'(m_add), 64'h3000_000C);
      tick();
      s_req = '0;
      m_gnt = 1'b0;
      m_r_valid = 1'b1;
      @(negedge clk);
      chk("bp_resp1", 64'(s_r_valid), 64'b0010);
      tick();
      @(negedge clk);
      chk("bp_resp3", 64'(s_r_valid), 64'b1000);
      tick();
      m_r_valid = 1'b0;

      // ---------------- FIFO full ----------------
      m_gnt = 1'b1;
      for (int k = 0; k < 4; k++) begin
         s_req = 4'(1 << k);
         @(negedge clk);
         chk("full_fill", 64'(s_gnt), 64'(1 << k));
         tick();
      end
      s_req = 4'b0010;
      @(negedge clk);
      chk("full_req", 64'(m_req), 64'd0);
      chk("full_gnt", 64'(s_gnt), 64'd0);
      chk("full_busy", 64'(busy), 64'd1);
      tick();
      m_r_valid = 1'b1;
      @(negedge clk);
      chk("full_req_pop", 64'(m_req), 64'd0);
      chk("full_gnt_pop", 64'(s_gnt), 64'd0);
      chk("full_route", 64'(s_r_valid), 64'b0001);
      tick();
      m_r_valid = 1'b0;
      @(negedge clk);
      chk("full_resume_req", 64'(m_req), 64'd1);
      chk("full_resume_gnt", 64'(s_gnt), 64'b0010);
      tick();
      s_req = '0;
      m_gnt = 1'b0;
      m_r_valid = 1'b1;
      drain_exp[0] = 4'b0010; drain_exp[1] = 4'b0100;
      drain_exp[2] = 4'b1000; drain_exp[3] = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("full_drain", 64'(s_r_valid), 64'(drain_exp[k]));
         tick();
      end
      m_r_valid = 1'b0;
      @(negedge clk);
      chk("full_idle", 64'(busy), 64'd0);
      tick();

      // ---------------- in-order routing ----------------
      ord_port[0] = 4'b1000; ord_port[1] = 4'b0001; ord_port[2] = 4'b0100;
      ord_data[0] = 32'h11;  ord_data[1] = 32'h22;  ord_data[2] = 32'h33;
      ord_opc[0]  = 1'b0;    ord_opc[1]  = 1'b1;    ord_opc[2]  = 1'b0;
      m_gnt = 1'b1;
      for (int k = 0; k < 3; k++) begin
         s_req = ord_port[k];
         @(negedge clk);
         chk("ord_gnt", 64'(s_gnt), 64'(ord_port[k]));
         tick();
      end
      s_req = '0;
      m_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         m_r_valid = 1'b1;
         m_r_rdata = ord_data[k];
         m_r_opc = ord_opc[k];
         @(negedge clk);
         chk("ord_rvalid", 64'(s_r_valid), 64'(ord_port[k]));
         chk("ord_rdata", 64'(s_r_rdata), 64'(ord_data[k]));
         chk("ord_opc", 64'(s_r_opc), 64'(ord_opc[k]));
         tick();
      end
      clr();

      // ---------------- spurious response ----------------
      m_r_valid = 1'b1;
      m_r_rdata = 32'h55;
      @(negedge clk);
      chk("spur_rvalid", 64'(s_r_valid), 64'd0);
      chk("spur_busy", 64'(busy), 64'd0);
      tick();
      m_r_valid = 1'b0;

      // ---------------- reset with transactions outstanding ----------------
      m_gnt = 1'b1;
      s_req = 4'b0010;
      tick();
      s_req = 4'b0100;
      tick();
      s_req = '0;
      m_gnt = 1'b0;
      @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_busy_rst", 64'(busy), 64'd0);
      tick();
      rst = 1'b0;
      m_r_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("mid_drop", 64'(s_r_valid), 64'd0);
         chk("mid_idle", 64'(busy), 64'd0);
         tick();
      end
      m_r_valid = 1'b0;
      s_req = 4'hF;
      m_gnt = 1'b1;
      @(negedge clk);
      chk("mid_rr_reset", 64'(s_gnt), 64'b0001);
      tick();
      clr();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
